// File: rtl/shift_add_multiplier.sv
// shift_add_multiplier: sequential unsigned WIDTH x WIDTH shift-add multiplier around an external adder
module shift_add_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output logic [WIDTH-1:0]   add_x,
  output logic [WIDTH-1:0]   add_y,
  input  logic [WIDTH-1:0]   add_sum,
  input  logic               add_c8
);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  logic [1:0]         state_q, state_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   mq_q, mq_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [CW-1:0]      count_q, count_d;
  logic [2*WIDTH-1:0] product_q, product_d;
  logic               run, accept, last;
  assign busy    = state_q == RUN;
  assign done    = state_q == DONE;
  assign product = product_q;
  // next-state: adder operands come only from registers, the adder result only feeds D-inputs
  always_comb begin
    run       = state_q == RUN;
    accept    = start && !run;
    last      = run && count_q == CW'(WIDTH - 1);
    add_x     = run ? acc_q : '0;
    add_y     = (run && mq_q[0]) ? mcand_q : '0;
    state_d   = accept ? RUN : run ? (last ? DONE : RUN) : IDLE;
    acc_d     = accept ? '0 : run ? {add_c8, add_sum[WIDTH-1:1]} : acc_q;
    mq_d      = accept ? b : run ? {add_sum[0], mq_q[WIDTH-1:1]} : mq_q;
    mcand_d   = accept ? a : mcand_q;
    count_d   = accept ? '0 : run ? count_q + CW'(1) : count_q;
    product_d = last ? {add_c8, add_sum, mq_q[WIDTH-1:1]} : product_q;
  end
  // state registers, cleared asynchronously so an in-flight operation is dropped at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      mq_q      <= '0;
      mcand_q   <= '0;
      count_q   <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      mq_q      <= mq_d;
      mcand_q   <= mcand_d;
      count_q   <= count_d;
      product_q <= product_d;
    end
  end
endmodule

// File: tb/tb_shift_add_multiplier.sv
// tb_shift_add_multiplier: directed and random checks of the shift-add multiplier against plain multiplication
module tb_shift_add_multiplier;
  logic        clk = 0, rst = 1, start = 0;
  logic [7:0]  a = 0, b = 0;
  logic        busy, done, add_c8;
  logic [15:0] product;
  logic [7:0]  add_x, add_y, add_sum;
  int          checks = 0, errors = 0;
  logic [15:0] exp_prod = 0;
  shift_add_multiplier #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .product(product),
    .add_x(add_x), .add_y(add_y), .add_sum(add_sum), .add_c8(add_c8)
  );
  always #5 clk = ~clk;
  always_comb {add_c8, add_sum} = {1'b0, add_x} + {1'b0, add_y};
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic accept(input logic [7:0] x, input logic [7:0] y);
    start = 1; a = x; b = y;
    tick();
    start = 0;
  endtask
  task automatic run_check(input logic [7:0] x, input logic [7:0] y, input bit y0, input int pulse_at);
    for (int i = 0; i < 8; i++) begin
      chk("run_busy", busy, 1);
      chk("run_done", done, 0);
      chk("run_hold", product, exp_prod);
      if (y0) chk("run_add_y_zero", add_y, 0);
      if (i == pulse_at) begin
        start = 1; a = 8'h11; b = 8'h22;
      end else start = 0;
      tick();
    end
    start = 0;
    exp_prod = 16'(x) * 16'(y);
    chk("done_pulse", done, 1);
    chk("done_busy", busy, 0);
    chk("product", product, exp_prod);
    chk("done_add_x", add_x, 0);
    chk("done_add_y", add_y, 0);
  endtask
  task automatic mul(input logic [7:0] x, input logic [7:0] y, input bit y0, input int pulse_at);
    accept(x, y);
    run_check(x, y, y0, pulse_at);
    tick();
    chk("idle_done", done, 0);
    chk("idle_busy", busy, 0);
    chk("idle_product", product, exp_prod);
  endtask
  initial begin
    logic [7:0] rx, ry;
    tick();
    tick();
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_product", product, 0);
    chk("reset_add_x", add_x, 0);
    rst = 0;
    tick();
    chk("idle_add_y", add_y, 0);
    mul(8'h0F, 8'h0F, 0, -1);
    chk("t1_value", product, 16'h00E1);
    mul(8'hFF, 8'hFF, 0, -1);
    chk("t2_max", product, 16'hFE01);
    mul(8'h80, 8'h02, 0, -1);
    mul(8'h00, 8'hA5, 0, -1);
    mul(8'h37, 8'h00, 1, -1);
    mul(8'h0C, 8'h0D, 0, 3);
    chk("t4_value", product, 16'h009C);
    accept(8'h03, 8'h05);
    run_check(8'h03, 8'h05, 0, -1);
    accept(8'h12, 8'h34);
    run_check(8'h12, 8'h34, 0, -1);
    chk("t5_value", product, 16'h03A8);
    tick();
    accept(8'hC3, 8'h5A);
    repeat (4) tick();
    chk("pre_rst_busy", busy, 1);
    #2 rst = 1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_product", product, 0);
    chk("arst_add_x", add_x, 0);
    chk("arst_add_y", add_y, 0);
    exp_prod = 0;
    rst = 0;
    tick();
    chk("post_rst_busy", busy, 0);
    chk("post_rst_done", done, 0);
    mul(8'h02, 8'h03, 0, -1);
    chk("t6_value", product, 16'h0006);
    for (int k = 0; k < 10; k++) begin
      rx = 8'($urandom);
      ry = 8'($urandom);
      mul(rx, ry, ry == 0, -1);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/shift_add_multiplier.md
Name: shift_add_multiplier

Overview:
Sequential unsigned WIDTH x WIDTH shift-add multiplier. It sits directly around the team's conditional sum adder: it drives the adder operands every cycle and consumes the adder's sum and carry-out. It produces a 2*WIDTH product after WIDTH iteration cycles, using a start/busy/done handshake.

Parameters:
WIDTH, 8, operand width. Must match the conditional sum adder width. Product width is 2*WIDTH.

Ports:
clk  input  1  system clock; all state updates on the rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  request strobe; sampled only when the block is idle or done
a  input  WIDTH  multiplicand; captured on the accepted start edge
b  input  WIDTH  multiplier; captured on the accepted start edge
busy  output  1  high while an iteration is in progress
done  output  1  one-cycle pulse; product valid
product  output  2*WIDTH  result; holds until the next accepted start
add_x  output  WIDTH  adder operand X (combinational from registers)
add_y  output  WIDTH  adder operand Y (combinational from registers)
add_sum  input  WIDTH  adder sum, combinational return
add_c8  input  1  adder carry-out, combinational return

Behaviour:
- Interface rule: clk, asynchronous active-high rst.
- Reset, applied asynchronously at any time including mid-operation:
  - state=IDLE
  - busy=0, done=0
  - product=0
  - internal acc, mq, mcand, count all 0
  - add_x=0, add_y=0
  - any in-flight operation is discarded
- Internal registers:
  - acc[WIDTH-1:0]: partial-product high half
  - mq[WIDTH-1:0]: multiplier / product low half
  - mcand[WIDTH-1:0]
  - count: $clog2(WIDTH)+1 bits
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - busy=0, done=0, add_x=0, add_y=0
  - On start=1: mcand<=a, mq<=b, acc<=0, count<=0, go to RUN.
- RUN:
  - busy=1, done=0
  - add_x=acc; add_y = mq[0] ? mcand : 0
  - Each edge: {acc, mq} <= {add_c8, add_sum, mq} >> 1, i.e. acc<={add_c8, add_sum[WIDTH-1:1]}, mq<={add_sum[0], mq[WIDTH-1:1]}; count<=count+1.
  - When count==WIDTH-1 at the edge, go to DONE. On that same edge product<={add_c8, add_sum, mq[WIDTH-1:1]} is registered, so product is visible in the DONE cycle.
  - start is ignored in RUN; a and b are not re-sampled.
- DONE:
  - busy=0, done=1 for exactly one cycle, add_x=0, add_y=0
  - start=1: accepted exactly as in IDLE, go to RUN (back-to-back; no idle gap required).
  - Otherwise go to IDLE.
- Latency: start accepted on edge E0. RUN occupies the cycles after edges E0..E7 (WIDTH cycles). done is high in the cycle after edge E8. Throughput is one product per WIDTH+1 cycles.
- Arithmetic:
  - Unsigned only.
  - Carry-out add_c8 must be captured into acc bit WIDTH-1 each iteration; dropping it is a failure for a,b >= 0x80.
  - The maximum result 0xFF*0xFF=0xFE01 fits 2*WIDTH with no overflow.
- product updates only on the final RUN edge; it is stable in IDLE, DONE and the next RUN until that run's final edge.
- Combinational loop: add_x/add_y depend only on registers; add_sum/add_c8 feed only register D-inputs. There is no combinational path from add_sum to add_x/add_y.

Test Plan:
1. Reset, then start with a=0x0F, b=0x0F. Required: busy high for 8 cycles; done pulse in cycle 9 after the accept edge; product=0x00E1.
2. a=0xFF, b=0xFF. Required: product=0xFE01 (exercises add_c8 on every iteration). Also a=0x80, b=0x02 gives product=0x0100.
3. a=0x00, b=0xA5 and a=0x37, b=0x00. Required: product=0x0000; add_y=0 in every RUN cycle of the second case.
4. start pulsed mid-RUN with a=0x11, b=0x22 during a 0x0C*0x0D run. Required: ignored; product=0x009C; no second done.
5. Back-to-back: start held during the DONE cycle with a=0x12, b=0x34 after 0x03*0x05. Required: first product=0x000F; second run begins immediately; product=0x03A8 nine cycles later.
6. rst asserted asynchronously between edges mid-RUN (count=4). Required: busy, done and product go to 0 immediately; FSM in IDLE; a new start 0x02*0x03 yields product=0x0006.
